// File: rtl/toy_bus_pkg.sv
// Shared toy-bus response definitions: field widths, opcodes, agent ids and the packed
// response beat used by the dispatch FIFOs.
package toy_bus_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int OPC_W  = 1;

  localparam logic [OPC_W-1:0] OPC_ACK = 1'b0;
  localparam logic [OPC_W-1:0] OPC_ERR = 1'b1;

  localparam logic [ID_W-1:0] LSU_ID = 4'd0;
  localparam logic [ID_W-1:0] DBG_ID = 4'd1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [OPC_W-1:0]  opcode;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
  } toy_bus_ack_t;

  localparam int ACK_W = $bits(toy_bus_ack_t);

endpackage

// File: rtl/toy_bus_resp_dispatch_lsu_dbg_if.sv
// One valid/ready response stream; master drives valid and payload, slave drives ready.
interface toy_bus_resp_dispatch_lsu_dbg_if;
  import toy_bus_pkg::*;

  logic              vld;
  logic              rdy;
  logic [DATA_W-1:0] data;
  logic [OPC_W-1:0]  opcode;
  logic [ID_W-1:0]   src_id;
  logic [ID_W-1:0]   tgt_id;

  modport master (output vld, output data, output opcode, output src_id, output tgt_id,
                  input rdy);
  modport slave  (input vld, input data, input opcode, input src_id, input tgt_id,
                  output rdy);

endinterface

// File: rtl/toy_bus_resp_fifo.sv
// Small synchronous FIFO for one dispatch output; head reads as zero while empty so the
// consumer never sees stale payload.
module toy_bus_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 41
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says an entry is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/toy_bus_resp_dispatch_lsu_dbg.sv
// Routes bus response beats by tgt_id to the lsu (out0) or dbg (out1) port through per-port FIFOs.
// Optional TOY_BUS_RESP_DISPATCH_PERF_EN adds saturating pop counters perf_cnt0/perf_cnt1.
module toy_bus_resp_dispatch_lsu_dbg
  import toy_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] OUT0_ID    = LSU_ID,
  parameter logic [ID_W-1:0] OUT1_ID    = DBG_ID,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  toy_bus_resp_dispatch_lsu_dbg_if.slave  in_bus,
  toy_bus_resp_dispatch_lsu_dbg_if.master out0,
  toy_bus_resp_dispatch_lsu_dbg_if.master out1,
  input  logic err_clr,
  output logic err_unroutable
`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
  ,
  output logic [15:0] perf_cnt0,
  output logic [15:0] perf_cnt1
`endif
);

  logic         hit0, hit1, miss;
  logic         full0, full1, empty0, empty1;
  logic         accept, push0, push1, pop0, pop1;
  toy_bus_ack_t in_beat, head0, head1;

  assign hit0 = (in_bus.tgt_id == OUT0_ID);
  assign hit1 = (in_bus.tgt_id == OUT1_ID);
  assign miss = ~hit0 & ~hit1;

  // Ready looks only at fullness, never at the consumer's ready, so no rdy->rdy path exists.
  assign in_bus.rdy = (hit0 & ~full0) | (hit1 & ~full1) | miss;

  assign accept = in_bus.vld & in_bus.rdy;
  assign push0  = accept & hit0;
  assign push1  = accept & hit1;
  assign pop0   = ~empty0 & out0.rdy;
  assign pop1   = ~empty1 & out1.rdy;

  assign in_beat = '{data:   in_bus.data,
                     opcode: in_bus.opcode,
                     src_id: in_bus.src_id,
                     tgt_id: in_bus.tgt_id};

  toy_bus_resp_fifo #(.DEPTH(FIFO_DEPTH), .W(ACK_W)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .pop   (pop0),
    .din   (in_beat),
    .head  (head0),
    .full  (full0),
    .empty (empty0)
  );

  toy_bus_resp_fifo #(.DEPTH(FIFO_DEPTH), .W(ACK_W)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .pop   (pop1),
    .din   (in_beat),
    .head  (head1),
    .full  (full1),
    .empty (empty1)
  );

  assign out0.vld    = ~empty0;
  assign out0.data   = head0.data;
  assign out0.opcode = head0.opcode;
  assign out0.src_id = head0.src_id;
  assign out0.tgt_id = head0.tgt_id;

  assign out1.vld    = ~empty1;
  assign out1.data   = head1.data;
  assign out1.opcode = head1.opcode;
  assign out1.src_id = head1.src_id;
  assign out1.tgt_id = head1.tgt_id;

  // A dropped beat in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unroutable <= 1'b0;
    end else if (accept && miss) begin
      err_unroutable <= 1'b1;
    end else if (err_clr) begin
      err_unroutable <= 1'b0;
    end
  end

`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else if (err_clr) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else begin
      if (pop0 && perf_cnt0 != 16'hFFFF) perf_cnt0 <= perf_cnt0 + 16'd1;
      if (pop1 && perf_cnt1 != 16'hFFFF) perf_cnt1 <= perf_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_toy_bus_resp_dispatch_lsu_dbg.sv
// Directed bench for toy_bus_resp_dispatch_lsu_dbg; honours TOY_BUS_RESP_DISPATCH_PERF_EN.
module tb_toy_bus_resp_dispatch_lsu_dbg;
  import toy_bus_pkg::*;

  logic clk;
  logic rst_n;
  logic err_clr;
  logic err_unroutable;
`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
  logic [15:0] perf_cnt0;
  logic [15:0] perf_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  toy_bus_resp_dispatch_lsu_dbg_if in_if ();
  toy_bus_resp_dispatch_lsu_dbg_if o0_if ();
  toy_bus_resp_dispatch_lsu_dbg_if o1_if ();

  toy_bus_resp_dispatch_lsu_dbg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_bus         (in_if.slave),
    .out0           (o0_if.master),
    .out1           (o1_if.master),
    .err_clr        (err_clr),
    .err_unroutable (err_unroutable)
`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
    ,
    .perf_cnt0      (perf_cnt0),
    .perf_cnt1      (perf_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [3:0] tgt, input logic [31:0] data,
                               input logic opc, input logic [3:0] src);
    in_if.vld    = vld;
    in_if.tgt_id = tgt;
    in_if.data   = data;
    in_if.opcode = opc;
    in_if.src_id = src;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    err_clr   = 1'b0;
    o0_if.rdy = 1'b1;
    o1_if.rdy = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'h0, OPC_ACK, 4'd0);

    // Reset state
    #10;
    checkOutput("rst_out0_vld", 64'(o0_if.vld), 64'd0);
    checkOutput("rst_out1_vld", 64'(o1_if.vld), 64'd0);
    checkOutput("rst_err", 64'(err_unroutable), 64'd0);
    checkOutput("rst_out0_data", 64'(o0_if.data), 64'd0);
    checkOutput("rst_out1_data", 64'(o1_if.data), 64'd0);
    checkOutput("rst_in_rdy_t0", 64'(in_if.rdy), 64'd1);
    applyStimulus(1'b0, 4'd1, 32'h0, OPC_ACK, 4'd0);
    checkOutput("rst_in_rdy_t1", 64'(in_if.rdy), 64'd1);
    rst_n = 1'b1;
    tick();

    // Route: back-to-back beats to each port
    applyStimulus(1'b1, 4'd0, 32'hA5A5_0001, OPC_ACK, 4'd2);
    checkOutput("route_rdy0", 64'(in_if.rdy), 64'd1);
    tick();
    checkOutput("route_out0_vld", 64'(o0_if.vld), 64'd1);
    checkOutput("route_out0_data", 64'(o0_if.data), 64'hA5A5_0001);
    checkOutput("route_out0_src", 64'(o0_if.src_id), 64'd2);
    checkOutput("route_out0_tgt", 64'(o0_if.tgt_id), 64'd0);
    checkOutput("route_out1_idle", 64'(o1_if.vld), 64'd0);
    applyStimulus(1'b1, 4'd1, 32'h5A5A_0002, OPC_ERR, 4'd3);
    checkOutput("route_rdy1", 64'(in_if.rdy), 64'd1);
    tick();
    checkOutput("route_out1_vld", 64'(o1_if.vld), 64'd1);
    checkOutput("route_out1_data", 64'(o1_if.data), 64'h5A5A_0002);
    checkOutput("route_out1_opc", 64'(o1_if.opcode), 64'd1);
    checkOutput("route_out1_src", 64'(o1_if.src_id), 64'd3);
    checkOutput("route_out0_popped", 64'(o0_if.vld), 64'd0);
    applyStimulus(1'b0, 4'd0, 32'h0, OPC_ACK, 4'd0);
    tick();
    checkOutput("route_out1_popped", 64'(o1_if.vld), 64'd0);

    // Isolation: stalled out0 does not block out1
    o0_if.rdy = 1'b0;
    applyStimulus(1'b1, 4'd0, 32'h1, OPC_ACK, 4'd5);
    tick();
    applyStimulus(1'b1, 4'd0, 32'h2, OPC_ACK, 4'd5);
    tick();
    applyStimulus(1'b1, 4'd0, 32'h3, OPC_ACK, 4'd5);
    checkOutput("iso_full_rdy", 64'(in_if.rdy), 64'd0);
    applyStimulus(1'b1, 4'd1, 32'h11, OPC_ACK, 4'd6);
    checkOutput("iso_out1_rdy", 64'(in_if.rdy), 64'd1);
    tick();
    checkOutput("iso_out1_vld", 64'(o1_if.vld), 64'd1);
    checkOutput("iso_out1_data", 64'(o1_if.data), 64'h11);
    checkOutput("iso_out0_head", 64'(o0_if.data), 64'h1);

    // Full FIFO refuses push even while popping; order preserved
    o0_if.rdy = 1'b1;
    applyStimulus(1'b1, 4'd0, 32'h3, OPC_ACK, 4'd5);
    checkOutput("full_pop_rdy", 64'(in_if.rdy), 64'd0);
    tick();
    checkOutput("full_head2", 64'(o0_if.data), 64'h2);
    checkOutput("full_retry_rdy", 64'(in_if.rdy), 64'd1);
    tick();
    checkOutput("full_head3", 64'(o0_if.data), 64'h3);
    applyStimulus(1'b0, 4'd0, 32'h0, OPC_ACK, 4'd0);
    tick();
    checkOutput("full_drained", 64'(o0_if.vld), 64'd0);
`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
    checkOutput("perf_cnt0", 64'(perf_cnt0), 64'd4);
    checkOutput("perf_cnt1", 64'(perf_cnt1), 64'd2);
`endif

    // Unroutable beats and sticky error flag
    applyStimulus(1'b1, 4'hF, 32'hDEAD_BEEF, OPC_ACK, 4'd7);
    checkOutput("miss_rdy", 64'(in_if.rdy), 64'd1);
    tick();
    checkOutput("miss_err_set", 64'(err_unroutable), 64'd1);
    checkOutput("miss_no_out0", 64'(o0_if.vld), 64'd0);
    checkOutput("miss_no_out1", 64'(o1_if.vld), 64'd0);
    applyStimulus(1'b0, 4'd0, 32'h0, OPC_ACK, 4'd0);
    err_clr = 1'b1;
    tick();
    checkOutput("miss_err_clr", 64'(err_unroutable), 64'd0);
`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
    checkOutput("perf_clr0", 64'(perf_cnt0), 64'd0);
`endif
    applyStimulus(1'b1, 4'hE, 32'h0, OPC_ACK, 4'd7);
    tick();
    checkOutput("miss_set_wins", 64'(err_unroutable), 64'd1);
    err_clr = 1'b0;

    // Reset mid-flight discards buffered beats
    applyStimulus(1'b1, 4'd1, 32'h21, OPC_ACK, 4'd8);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, OPC_ACK, 4'd0);
    tick();
    o1_if.rdy = 1'b0;
    applyStimulus(1'b1, 4'd1, 32'h22, OPC_ACK, 4'd8);
    tick();
    applyStimulus(1'b1, 4'd1, 32'h23, OPC_ACK, 4'd8);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, OPC_ACK, 4'd0);
    checkOutput("mid_out1_vld", 64'(o1_if.vld), 64'd1);
    checkOutput("mid_out1_head", 64'(o1_if.data), 64'h22);
    checkOutput("mid_full_rdy", 64'(in_if.tgt_id == 4'd1 ? in_if.rdy : 1'b1), 64'd1);
`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
    checkOutput("perf_mid1", 64'(perf_cnt1), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out1_vld", 64'(o1_if.vld), 64'd0);
    checkOutput("mid_rst_err", 64'(err_unroutable), 64'd0);
`ifdef TOY_BUS_RESP_DISPATCH_PERF_EN
    checkOutput("perf_rst1", 64'(perf_cnt1), 64'd0);
`endif
    #10;
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'd1, 32'h0, OPC_ACK, 4'd0);
    tick();
    checkOutput("post_rst_out1_vld", 64'(o1_if.vld), 64'd0);
    checkOutput("post_rst_rdy1", 64'(in_if.rdy), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
